// File: rtl/snax_block_transpose_reshuffler.sv
// Moves NUM_BLOCKS NxN element blocks between TCDM regions, copied as-is or element-transposed.
// Latency: 3 cycles per block when all ports are ready and read data returns one cycle after acceptance.
// Backpressure: each port holds addr/data until q_ready; CSR writes stall while busy, CSR requests stall on an unconsumed read response.
module snax_block_transpose_reshuffler #(
    parameter int unsigned DataWidth     = 64,
    parameter int unsigned NumChannels   = 8,
    parameter int unsigned TCDMAddrWidth = 48
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [31:0]                          io_csr_req_bits_data_i,
    input  logic [31:0]                          io_csr_req_bits_addr_i,
    input  logic                                 io_csr_req_bits_write_i,
    input  logic                                 io_csr_req_valid_i,
    output logic                                 io_csr_req_ready_o,
    output logic                                 io_csr_rsp_valid_o,
    input  logic                                 io_csr_rsp_ready_i,
    output logic [31:0]                          io_csr_rsp_bits_data_o,
    output logic [NumChannels-1:0]               tcdm_req_write_o,
    output logic [NumChannels*TCDMAddrWidth-1:0] tcdm_req_addr_o,
    output logic [NumChannels*4-1:0]             tcdm_req_amo_o,
    output logic [NumChannels*DataWidth-1:0]     tcdm_req_data_o,
    output logic [NumChannels*5-1:0]             tcdm_req_user_core_id_o,
    output logic [NumChannels-1:0]               tcdm_req_user_is_core_o,
    output logic [NumChannels*DataWidth/8-1:0]   tcdm_req_strb_o,
    output logic [NumChannels-1:0]               tcdm_req_q_valid_o,
    input  logic [NumChannels-1:0]               tcdm_rsp_q_ready_i,
    input  logic [NumChannels-1:0]               tcdm_rsp_p_valid_i,
    input  logic [NumChannels*DataWidth-1:0]     tcdm_rsp_data_i,
    output logic                                 busy_o
);

    localparam int unsigned N         = NumChannels;
    localparam int unsigned AW        = TCDMAddrWidth;
    localparam int unsigned ElemWidth = DataWidth / NumChannels;

    typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2} state_e;

    state_e               state_q, state_d;
    logic [31:0]          csr_q [8];
    logic [N-1:0]         issued_q, received_q;
    logic [N-1:0]         req_hs, rsp_take;
    logic [DataWidth-1:0] row_buf_q [N];
    logic [AW-1:0]        blk_src_q, blk_dst_q;
    logic [31:0]          blk_cnt_q, perf_q;
    logic                 rsp_pending_q;
    logic [31:0]          rsp_data_q, rd_data;
    logic                 csr_fire, csr_wr, start, all_rcvd, all_wr;
    logic                 blk_last, run_start, blk_done;

    assign csr_fire  = io_csr_req_valid_i & io_csr_req_ready_o;
    assign csr_wr    = csr_fire & io_csr_req_bits_write_i;
    assign start     = csr_wr & (io_csr_req_bits_addr_i == 32'd8);
    assign req_hs    = tcdm_req_q_valid_o & tcdm_rsp_q_ready_i;
    // Late or duplicate responses (port not issued, already received, or outside READ) are dropped.
    assign rsp_take  = (state_q == READ) ? (tcdm_rsp_p_valid_i & issued_q & ~received_q) : '0;
    // Completion includes this cycle's handshakes so the state advances without an extra bubble.
    assign all_rcvd  = &(received_q | rsp_take);
    assign all_wr    = &(issued_q | req_hs);
    assign blk_last  = (blk_cnt_q + 32'd1) == csr_q[6];
    assign run_start = (state_q == IDLE) && (state_d == READ);
    assign blk_done  = (state_q == WRITE) && all_wr;

    assign io_csr_req_ready_o     = ~rsp_pending_q & ((state_q == IDLE) | ~io_csr_req_bits_write_i);
    assign io_csr_rsp_valid_o     = rsp_pending_q;
    assign io_csr_rsp_bits_data_o = rsp_data_q;

    assign tcdm_req_amo_o          = '0;
    assign tcdm_req_user_core_id_o = '0;
    assign tcdm_req_user_is_core_o = '0;
    assign tcdm_req_strb_o         = '1;

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: a START with zero blocks leaves the engine idle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && csr_q[6] != 32'd0) state_d = READ;
            READ:    if (all_rcvd) state_d = WRITE;
            WRITE:   if (all_wr) state_d = blk_last ? IDLE : READ;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: per-port request until accepted, copy or element-transpose of the row buffers
    always_comb begin
        busy_o             = (state_q != IDLE);
        tcdm_req_q_valid_o = '0;
        tcdm_req_write_o   = '0;
        tcdm_req_addr_o    = '0;
        tcdm_req_data_o    = '0;
        for (int unsigned p = 0; p < N; p++) begin
            if (state_q == READ) begin
                tcdm_req_q_valid_o[p]       = ~issued_q[p];
                tcdm_req_addr_o[p*AW +: AW] = blk_src_q + AW'(p) * AW'(csr_q[2]);
            end else if (state_q == WRITE) begin
                tcdm_req_q_valid_o[p]       = ~issued_q[p];
                tcdm_req_write_o[p]         = 1'b1;
                tcdm_req_addr_o[p*AW +: AW] = blk_dst_q + AW'(p) * AW'(csr_q[3]);
                for (int unsigned e = 0; e < N; e++) begin
                    tcdm_req_data_o[p*DataWidth + e*ElemWidth +: ElemWidth] = csr_q[7][0]
                        ? row_buf_q[e][p*ElemWidth +: ElemWidth]
                        : row_buf_q[p][e*ElemWidth +: ElemWidth];
                end
            end
        end
    end

    // Handshake masks restart on every state change; block pointers advance after each block's writes
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            issued_q   <= '0;
            received_q <= '0;
            blk_src_q  <= '0;
            blk_dst_q  <= '0;
            blk_cnt_q  <= '0;
        end else begin
            if (state_d != state_q) begin
                issued_q   <= '0;
                received_q <= '0;
            end else begin
                issued_q   <= issued_q | req_hs;
                received_q <= received_q | rsp_take;
            end
            if (run_start) begin
                blk_src_q <= AW'(csr_q[0]);
                blk_dst_q <= AW'(csr_q[1]);
                blk_cnt_q <= '0;
            end else if (blk_done) begin
                blk_src_q <= blk_src_q + AW'(csr_q[4]);
                blk_dst_q <= blk_dst_q + AW'(csr_q[5]);
                blk_cnt_q <= blk_cnt_q + 32'd1;
            end
        end
    end

    // Row buffers capture read data per port; contents are don't-care until written
    always_ff @(posedge clk_i) begin
        for (int unsigned r = 0; r < N; r++) begin
            if (rsp_take[r]) row_buf_q[r] <= tcdm_rsp_data_i[r*DataWidth +: DataWidth];
        end
    end

    // Busy-cycle counter: cleared by a real start, saturates at all ones
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_q <= '0;
        end else if (run_start) begin
            perf_q <= '0;
        end else if (busy_o && perf_q != '1) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    // Writable CSRs 0..7; START, read-only and unmapped indices do not store
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 8; i++) csr_q[i] <= '0;
        end else if (csr_wr && io_csr_req_bits_addr_i < 32'd8) begin
            csr_q[io_csr_req_bits_addr_i[2:0]] <= io_csr_req_bits_data_i;
        end
    end

    // CSR read mux; unmapped indices read as zero
    always_comb begin
        rd_data = '0;
        if (io_csr_req_bits_addr_i < 32'd8) begin
            rd_data = csr_q[io_csr_req_bits_addr_i[2:0]];
        end else if (io_csr_req_bits_addr_i == 32'd9) begin
            rd_data = {31'd0, busy_o};
        end else if (io_csr_req_bits_addr_i == 32'd10) begin
            rd_data = perf_q;
        end
    end

    // Read response register, held until the requester takes it
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_pending_q <= 1'b0;
            rsp_data_q    <= '0;
        end else if (csr_fire && !io_csr_req_bits_write_i) begin
            rsp_pending_q <= 1'b1;
            rsp_data_q    <= rd_data;
        end else if (rsp_pending_q && io_csr_rsp_ready_i) begin
            rsp_pending_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_snax_block_transpose_reshuffler.sv
// Directed bench for the block reshuffler with a one-cycle-latency TCDM model.
// Covers reset, copy, transpose, per-port stall, multi-block and CSR corner cases.
// Inputs change on the falling edge; outputs are sampled on the falling edge or just after the rising edge.
`timescale 1ns/1ps
module tb_snax_block_transpose_reshuffler;
    localparam int N  = 8;
    localparam int DW = 64;
    localparam int AW = 48;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic [31:0]     io_csr_req_bits_data_i = '0;
    logic [31:0]     io_csr_req_bits_addr_i = '0;
    logic            io_csr_req_bits_write_i = 1'b0;
    logic            io_csr_req_valid_i = 1'b0;
    logic            io_csr_req_ready_o;
    logic            io_csr_rsp_valid_o;
    logic            io_csr_rsp_ready_i = 1'b1;
    logic [31:0]     io_csr_rsp_bits_data_o;
    logic [N-1:0]    tcdm_req_write_o;
    logic [N*AW-1:0] tcdm_req_addr_o;
    logic [N*4-1:0]  tcdm_req_amo_o;
    logic [N*DW-1:0] tcdm_req_data_o;
    logic [N*5-1:0]  tcdm_req_user_core_id_o;
    logic [N-1:0]    tcdm_req_user_is_core_o;
    logic [N*DW/8-1:0] tcdm_req_strb_o;
    logic [N-1:0]    tcdm_req_q_valid_o;
    logic [N-1:0]    tcdm_rsp_q_ready_i = '1;
    logic [N-1:0]    tcdm_rsp_p_valid_i = '0;
    logic [N*DW-1:0] tcdm_rsp_data_i = '0;
    logic            busy_o;

    always #5 clk_i = ~clk_i;

    snax_block_transpose_reshuffler #(
        .DataWidth(DW), .NumChannels(N), .TCDMAddrWidth(AW)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .io_csr_req_bits_data_i(io_csr_req_bits_data_i),
        .io_csr_req_bits_addr_i(io_csr_req_bits_addr_i),
        .io_csr_req_bits_write_i(io_csr_req_bits_write_i),
        .io_csr_req_valid_i(io_csr_req_valid_i),
        .io_csr_req_ready_o(io_csr_req_ready_o),
        .io_csr_rsp_valid_o(io_csr_rsp_valid_o),
        .io_csr_rsp_ready_i(io_csr_rsp_ready_i),
        .io_csr_rsp_bits_data_o(io_csr_rsp_bits_data_o),
        .tcdm_req_write_o(tcdm_req_write_o),
        .tcdm_req_addr_o(tcdm_req_addr_o),
        .tcdm_req_amo_o(tcdm_req_amo_o),
        .tcdm_req_data_o(tcdm_req_data_o),
        .tcdm_req_user_core_id_o(tcdm_req_user_core_id_o),
        .tcdm_req_user_is_core_o(tcdm_req_user_is_core_o),
        .tcdm_req_strb_o(tcdm_req_strb_o),
        .tcdm_req_q_valid_o(tcdm_req_q_valid_o),
        .tcdm_rsp_q_ready_i(tcdm_rsp_q_ready_i),
        .tcdm_rsp_p_valid_i(tcdm_rsp_p_valid_i),
        .tcdm_rsp_data_i(tcdm_rsp_data_i),
        .busy_o(busy_o)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] mem [logic [AW-1:0]];
    logic [AW-1:0] last_rd [N];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mem_rd(input logic [AW-1:0] a);
        return mem.exists(a) ? mem[a] : 64'h0;
    endfunction

    function automatic logic [AW-1:0] port_addr(input int r);
        return tcdm_req_addr_o[r*AW +: AW];
    endfunction

    // TCDM model: writes land at the edge, reads answer one cycle after acceptance
    always @(posedge clk_i) begin
        logic [N-1:0]    pv;
        logic [N*DW-1:0] pd;
        pv = '0;
        pd = '0;
        for (int r = 0; r < N; r++) begin
            if (tcdm_req_q_valid_o[r] && tcdm_rsp_q_ready_i[r]) begin
                if (tcdm_req_write_o[r]) begin
                    mem[port_addr(r)] = tcdm_req_data_o[r*DW +: DW];
                end else begin
                    pv[r] = 1'b1;
                    pd[r*DW +: DW] = mem_rd(port_addr(r));
                    last_rd[r] = port_addr(r);
                end
            end
        end
        tcdm_rsp_p_valid_i <= pv;
        tcdm_rsp_data_i    <= pd;
    end

    task automatic csr_write(input logic [31:0] a, input logic [31:0] d, output int stall);
        stall = 0;
        @(negedge clk_i);
        io_csr_req_valid_i = 1'b1;
        io_csr_req_bits_write_i = 1'b1;
        io_csr_req_bits_addr_i = a;
        io_csr_req_bits_data_i = d;
        #1;
        while (!io_csr_req_ready_o && stall < 200) begin
            @(negedge clk_i);
            #1;
            stall++;
        end
        @(posedge clk_i);
        #1;
        io_csr_req_valid_i = 1'b0;
        io_csr_req_bits_write_i = 1'b0;
    endtask

    task automatic csr_read(input logic [31:0] a, output logic [31:0] d);
        int n;
        n = 0;
        @(negedge clk_i);
        io_csr_req_valid_i = 1'b1;
        io_csr_req_bits_write_i = 1'b0;
        io_csr_req_bits_addr_i = a;
        #1;
        while (!io_csr_req_ready_o && n < 200) begin
            @(negedge clk_i);
            #1;
            n++;
        end
        @(posedge clk_i);
        #1;
        io_csr_req_valid_i = 1'b0;
        n = 0;
        while (!io_csr_rsp_valid_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        check("csr_rsp_valid", 64'(io_csr_rsp_valid_o), 64'd1);
        d = io_csr_rsp_bits_data_o;
    endtask

    task automatic cfg(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] srs,
                       input logic [31:0] drs, input logic [31:0] sbs, input logic [31:0] dbs,
                       input logic [31:0] nb, input logic [31:0] mode);
        int s;
        csr_write(32'd0, src, s);
        csr_write(32'd1, dst, s);
        csr_write(32'd2, srs, s);
        csr_write(32'd3, drs, s);
        csr_write(32'd4, sbs, s);
        csr_write(32'd5, dbs, s);
        csr_write(32'd6, nb, s);
        csr_write(32'd7, mode, s);
    endtask

    // Leaves the caller at the falling edge of the first cycle after START is accepted
    task automatic start_run();
        int s;
        csr_write(32'd8, 32'd1, s);
        @(negedge clk_i);
    endtask

    // Counts busy cycles starting with the current falling edge
    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy_o && cyc < 500) begin
            cyc++;
            @(negedge clk_i);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int st, cyc;
        logic [31:0] rd;
        logic [63:0] v;

        // Reset values
        repeat (2) @(negedge clk_i);
        check("rst_qvld", 64'(tcdm_req_q_valid_o), 64'h0);
        check("rst_busy", 64'(busy_o), 64'h0);
        check("rst_rsp_vld", 64'(io_csr_rsp_valid_o), 64'h0);
        check("rst_req_rdy", 64'(io_csr_req_ready_o), 64'h1);
        check("rst_amo", 64'(tcdm_req_amo_o), 64'h0);
        check("rst_strb", tcdm_req_strb_o, 64'hFFFF_FFFF_FFFF_FFFF);
        check("rst_core_id", 64'(tcdm_req_user_core_id_o), 64'h0);
        check("rst_is_core", 64'(tcdm_req_user_is_core_o), 64'h0);
        rst_i = 1'b0;
        csr_read(32'd6, rd);
        check("rst_num_blocks", 64'(rd), 64'h0);

        // Copy, one block
        for (int r = 0; r < N; r++) mem[AW'(r*8)] = {32'hC0DE_0000 + 32'(r), 32'hFACE_0000 + 32'(r)};
        cfg(32'h0, 32'h400, 32'd8, 32'd8, 32'd0, 32'd0, 32'd1, 32'd0);
        start_run();
        check("cp_qvld_t1", 64'(tcdm_req_q_valid_o), 64'hFF);
        check("cp_busy_t1", 64'(busy_o), 64'h1);
        check("cp_rd_write_t1", 64'(tcdm_req_write_o), 64'h0);
        check("cp_addr7_t1", 64'(port_addr(7)), 64'h38);
        wait_idle(cyc);
        check("cp_busy_cycles", 64'(cyc), 64'd3);
        for (int r = 0; r < N; r++)
            check("cp_dst_row", mem_rd(AW'(32'h400 + r*8)), {32'hC0DE_0000 + 32'(r), 32'hFACE_0000 + 32'(r)});
        csr_read(32'd10, rd);
        check("cp_perf", 64'(rd), 64'd3);

        // Transpose, byte e of source row r = 8r+e
        for (int r = 0; r < N; r++) begin
            v = '0;
            for (int e = 0; e < N; e++) v[e*8 +: 8] = 8'(8*r + e);
            mem[AW'(32'h800 + r*8)] = v;
        end
        cfg(32'h800, 32'hC00, 32'd8, 32'd8, 32'd0, 32'd0, 32'd1, 32'd1);
        start_run();
        wait_idle(cyc);
        check("tp_busy_cycles", 64'(cyc), 64'd3);
        check("tp_row0", mem_rd(48'hC00), 64'h3830_2820_1810_0800);
        check("tp_row7", mem_rd(48'hC38), 64'h3F37_2F27_1F17_0F07);
        for (int j = 0; j < N; j++) begin
            v = '0;
            for (int i = 0; i < N; i++) v[i*8 +: 8] = 8'(8*i + j);
            check("tp_row", mem_rd(AW'(32'hC00 + j*8)), v);
        end

        // Port 3 stalled for the first five READ cycles
        cfg(32'h0, 32'h600, 32'd8, 32'd8, 32'd0, 32'd0, 32'd1, 32'd0);
        @(negedge clk_i);
        tcdm_rsp_q_ready_i = 8'hF7;
        start_run();
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk_i);
            check("bp_addr3_stable", 64'(port_addr(3)), 64'h18);
            check("bp_vld3", 64'(tcdm_req_q_valid_o[3]), 64'h1);
            if (k == 1) check("bp_others_dropped", 64'(tcdm_req_q_valid_o), 64'h08);
        end
        @(negedge clk_i);
        tcdm_rsp_q_ready_i = 8'hFF;
        wait_idle(cyc);
        check("bp_busy_tail", 64'(cyc), 64'd3);
        check("bp_dst_row3", mem_rd(48'h618), {32'hC0DE_0003, 32'hFACE_0003});
        check("bp_dst_row0", mem_rd(48'h600), {32'hC0DE_0000, 32'hFACE_0000});
        csr_read(32'd10, rd);
        check("bp_perf", 64'(rd), 64'd8);

        // Four blocks with block strides
        for (int a = 0; a < 32'h100; a += 8) mem[AW'(a)] = 64'hB10C_0000_0000_0000 | 64'(a);
        cfg(32'h0, 32'h2000, 32'd8, 32'd8, 32'h40, 32'h80, 32'd4, 32'd0);
        start_run();
        wait_idle(cyc);
        check("mb_busy_cycles", 64'(cyc), 64'd12);
        check("mb_last_rd0", 64'(last_rd[0]), 64'hC0);
        check("mb_last_rd7", 64'(last_rd[7]), 64'hF8);
        check("mb_blk3_row0", mem_rd(48'h2180), 64'hB10C_0000_0000_00C0);
        check("mb_blk3_row7", mem_rd(48'h21B8), 64'hB10C_0000_0000_00F8);
        check("mb_blk1_row2", mem_rd(48'h2090), 64'hB10C_0000_0000_0050);
        csr_read(32'd10, rd);
        check("mb_perf", 64'(rd), 64'd12);

        // START with zero blocks is a no-op
        csr_write(32'd6, 32'd0, st);
        start_run();
        check("nb0_busy", 64'(busy_o), 64'h0);
        check("nb0_qvld", 64'(tcdm_req_q_valid_o), 64'h0);
        repeat (2) @(negedge clk_i);
        check("nb0_busy_later", 64'(busy_o), 64'h0);
        csr_read(32'd9, rd);
        check("status_idle", 64'(rd), 64'h0);

        // STATUS read while busy
        csr_write(32'd6, 32'd1, st);
        start_run();
        csr_read(32'd9, rd);
        check("status_busy", 64'(rd), 64'h1);
        @(negedge clk_i);
        wait_idle(cyc);
        check("status_run_done", 64'(busy_o), 64'h0);

        // CSR write while busy stalls until IDLE
        csr_write(32'd8, 32'd1, st);
        csr_write(32'd0, 32'h1234, st);
        check("busy_wr_stall", 64'(st), 64'd3);
        csr_read(32'd0, rd);
        check("busy_wr_landed", 64'(rd), 64'h1234);

        // Read-only and unmapped CSRs
        csr_write(32'd10, 32'hDEAD, st);
        csr_read(32'd10, rd);
        check("perf_ro", 64'(rd), 64'd3);
        csr_read(32'd15, rd);
        check("unmapped_rd", 64'(rd), 64'h0);

        // Reset in the middle of a run
        cfg(32'h0, 32'h3000, 32'd8, 32'd8, 32'd0, 32'd0, 32'd1, 32'd0);
        start_run();
        check("mr_busy_before", 64'(busy_o), 64'h1);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("mr_qvld", 64'(tcdm_req_q_valid_o), 64'h0);
        check("mr_busy", 64'(busy_o), 64'h0);
        check("mr_req_rdy", 64'(io_csr_req_ready_o), 64'h1);
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check("mr_busy_after", 64'(busy_o), 64'h0);
        csr_read(32'd1, rd);
        check("mr_dst_cleared", 64'(rd), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
